// File: rtl/net_pkg.sv
// Shared slot constants and run-supervisor state encoding for the network solver.
package net_pkg;
  localparam int N_DEF = 5;
  localparam int W_DEF = 16;
  localparam int FRAME_LEN = 21;
  localparam logic [6:0] SAMPLE_SLOT = 7'd2;
  localparam logic [6:0] STOP_SLOT = 7'd20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } run_state_t;
endpackage

// File: rtl/net_conv_check.sv
// Per-iteration convergence test: holds the previous state snapshot and compares
// every element against it within a tolerance.
module net_conv_check
  import net_pkg::*;
#(
  parameter int           N   = N_DEF,
  parameter int           W   = W_DEF,
  parameter logic [W-1:0] TOL = W'(4)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_clear,
  input  logic           i_sample,
  input  logic [N*W-1:0] i_x,
  output logic           o_first,
  output logic           o_all_within
);
  logic [N*W-1:0] r_x_prev;
  logic           r_first;
  logic [N-1:0]   w_pass;

  // One extra bit keeps a full-scale swing from wrapping into a small difference.
  for (genvar k = 0; k < N; k++) begin : g_elem
    logic [W:0] w_diff;
    logic [W:0] w_abs;
    assign w_diff = {i_x[k*W+W-1], i_x[k*W +: W]}
                  - {r_x_prev[k*W+W-1], r_x_prev[k*W +: W]};
    assign w_abs = w_diff[W] ? -w_diff : w_diff;
    assign w_pass[k] = (w_abs <= {1'b0, TOL});
  end

  assign o_first = r_first;
  assign o_all_within = i_sample & ~r_first & (&w_pass);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_x_prev <= '0;
      r_first  <= 1'b1;
    end else if (i_clear) begin
      r_first <= 1'b1;
    end else if (i_sample) begin
      r_x_prev <= i_x;
      r_first  <= 1'b0;
    end
  end
endmodule

// File: rtl/net_run_ctrl.sv
// Run supervisor for the network state controller: load pulse, per-iteration
// sampling, and frame-aligned stop on convergence, timeout or abort.
module net_run_ctrl
  import net_pkg::*;
#(
  parameter int           N        = N_DEF,
  parameter int           W        = W_DEF,
  parameter logic [W-1:0] TOL      = W'(4),
  parameter int           CONV_CNT = 8,
  parameter int           MAX_ITER = 1000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           abort,
  input  logic [N*W-1:0] x_in,
  input  logic [6:0]     addder_in,
  output logic           en_out,
  output logic           init_load,
  output logic           busy,
  output logic           done,
  output logic           converged,
  output logic           timeout,
  output logic [15:0]    iter_cnt
);
  localparam logic [7:0]  CONV_TGT = 8'(CONV_CNT);
  localparam logic [15:0] ITER_TGT = 16'(MAX_ITER);

  run_state_t  r_state;
  logic [7:0]  r_stable;
  logic        r_stop_pend;
  logic        r_conv_flag;
  logic        r_to_flag;
  logic        w_sample;
  logic        w_clear;
  logic        w_first;
  logic        w_within;
  logic [15:0] w_iter_nxt;
  logic [7:0]  w_stable_nxt;

  assign w_sample   = (r_state == RUN) && (addder_in == SAMPLE_SLOT);
  assign w_clear    = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_iter_nxt = (iter_cnt == 16'hFFFF) ? iter_cnt : iter_cnt + 16'd1;

  always_comb begin
    w_stable_nxt = r_stable;
    if (!w_first) begin
      if (w_within) w_stable_nxt = (r_stable == 8'hFF) ? r_stable : r_stable + 8'd1;
      else          w_stable_nxt = 8'd0;
    end
  end

  net_conv_check #(.N(N), .W(W), .TOL(TOL)) u_conv (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_clear),
    .i_sample     (w_sample),
    .i_x          (x_in),
    .o_first      (w_first),
    .o_all_within (w_within)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      en_out      <= 1'b1;
      init_load   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      converged   <= 1'b0;
      timeout     <= 1'b0;
      iter_cnt    <= 16'd0;
      r_stable    <= 8'd0;
      r_stop_pend <= 1'b0;
      r_conv_flag <= 1'b0;
      r_to_flag   <= 1'b0;
    end else begin
      init_load <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state     <= LOAD;
            init_load   <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            converged   <= 1'b0;
            timeout     <= 1'b0;
            iter_cnt    <= 16'd0;
            r_stable    <= 8'd0;
            r_stop_pend <= 1'b0;
            r_conv_flag <= 1'b0;
            r_to_flag   <= 1'b0;
          end
        end
        LOAD: begin
          if (abort) begin
            r_state <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            r_state <= RUN;
            en_out  <= 1'b0;
          end
        end
        RUN: begin
          // Only the first stop reason is latched; convergence outranks timeout.
          if (w_sample) begin
            iter_cnt <= w_iter_nxt;
            r_stable <= w_stable_nxt;
            if (!r_conv_flag && !r_to_flag) begin
              if (w_stable_nxt >= CONV_TGT) begin
                r_conv_flag <= 1'b1;
                r_stop_pend <= 1'b1;
              end else if (w_iter_nxt >= ITER_TGT) begin
                r_to_flag   <= 1'b1;
                r_stop_pend <= 1'b1;
              end
            end
          end
          if (abort) r_stop_pend <= 1'b1;
          if (r_stop_pend && (addder_in == STOP_SLOT)) begin
            r_state   <= DONE;
            en_out    <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            converged <= r_conv_flag;
            timeout   <= r_to_flag;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_net_run_ctrl.sv
// Directed bench for net_run_ctrl: three instances (MAX_ITER 1000, 5, 9), each
// driven by a behavioural model of the state controller's slot counter.
module tb_net_run_ctrl;
  import net_pkg::*;

  localparam int N  = 5;
  localparam int W  = 16;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [N*W-1:0] x_in = '0;
  logic [6:0] add [ND];
  logic [ND-1:0] en, il, bsy, dn, cv, tmo;
  logic [ND-1:0][15:0] it;

  int checks = 0;
  int errors = 0;
  logic signed [W-1:0] seq [32];
  int seq_el = 0;
  int seq_k = 0;
  bit ok;

  always #5 clk = ~clk;

  // Slot counter model: held at 0 while en_out is high, else 1..21 wrapping.
  always_ff @(posedge clk)
    for (int d = 0; d < ND; d++)
      add[d] <= en[d] ? 7'd0 : ((add[d] == 7'(FRAME_LEN)) ? 7'd1 : add[d] + 7'd1);

  net_run_ctrl #(.MAX_ITER(1000)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .x_in(x_in), .addder_in(add[0]),
    .en_out(en[0]), .init_load(il[0]), .busy(bsy[0]), .done(dn[0]),
    .converged(cv[0]), .timeout(tmo[0]), .iter_cnt(it[0]));
  net_run_ctrl #(.MAX_ITER(5)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .x_in(x_in), .addder_in(add[1]),
    .en_out(en[1]), .init_load(il[1]), .busy(bsy[1]), .done(dn[1]),
    .converged(cv[1]), .timeout(tmo[1]), .iter_cnt(it[1]));
  net_run_ctrl #(.MAX_ITER(9)) u_dut2 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .x_in(x_in), .addder_in(add[2]),
    .en_out(en[2]), .init_load(il[2]), .busy(bsy[2]), .done(dn[2]),
    .converged(cv[2]), .timeout(tmo[2]), .iter_cnt(it[2]));

  task automatic apply_x(input int k);
    int kk;
    kk = (k > 31) ? 31 : k;
    x_in = '0;
    x_in[seq_el*W +: W] = seq[kk];
  endtask

  task automatic fill_seq(input logic signed [W-1:0] v);
    for (int i = 0; i < 32; i++) seq[i] = v;
  endtask

  task automatic pulse_reset();
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int d, input int budget, output bit got);
    got = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (dn[d]) begin
        got = 1'b1;
        break;
      end
      if (add[d] == 7'd3) begin
        seq_k++;
        apply_x(seq_k);
      end
    end
  endtask

  // Runs dut0 until it shows slot s of frame f; returns got=0 if the budget expires.
  task automatic run_to_slot(input int f, input logic [6:0] s, output bit got);
    int fc;
    fc = 0;
    got = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (add[0] == 7'd1) fc++;
      if (fc == f && add[0] == s) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      checks++; if (en[d] !== 1'b1) begin errors++; $display("FAIL reset_en d%0d got %b exp 1", d, en[d]); end
      checks++; if ({il[d], bsy[d], dn[d], cv[d], tmo[d]} !== 5'b0) begin errors++; $display("FAIL reset_flags d%0d got %b exp 00000", d, {il[d], bsy[d], dn[d], cv[d], tmo[d]}); end
      checks++; if (it[d] !== 16'd0) begin errors++; $display("FAIL reset_iter d%0d got %0d exp 0", d, it[d]); end
    end
    reset = 1'b1;
  endtask

  task automatic test_converge();
    fill_seq(16'sd0); seq_el = 0; seq_k = 0; apply_x(0);
    do_start();
    checks++; if ({il[0], en[0], bsy[0]} !== 3'b111) begin errors++; $display("FAIL load_outputs got %b exp 111", {il[0], en[0], bsy[0]}); end
    @(negedge clk);
    checks++; if ({il[0], en[0]} !== 2'b00) begin errors++; $display("FAIL run_entry got %b exp 00", {il[0], en[0]}); end
    wait_done(0, 400, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL conv_wait got %b exp 1", ok); end
    checks++; if (add[0] !== 7'd21 || en[0] !== 1'b1) begin errors++; $display("FAIL conv_boundary got slot %0d en %b exp slot 21 en 1", add[0], en[0]); end
    checks++; if (it[0] !== 16'd9) begin errors++; $display("FAIL conv_iter got %0d exp 9", it[0]); end
    checks++; if ({cv[0], tmo[0], bsy[0]} !== 3'b100) begin errors++; $display("FAIL conv_flags got %b exp 100", {cv[0], tmo[0], bsy[0]}); end
    checks++; if ({dn[1], cv[1], tmo[1]} !== 3'b101 || it[1] !== 16'd5) begin errors++; $display("FAIL conv_max5 got %b iter %0d exp 101 iter 5", {dn[1], cv[1], tmo[1]}, it[1]); end
    checks++; if ({dn[2], cv[2], tmo[2]} !== 3'b110 || it[2] !== 16'd9) begin errors++; $display("FAIL both_conds got %b iter %0d exp 110 iter 9", {dn[2], cv[2], tmo[2]}, it[2]); end
    @(negedge clk);
    checks++; if (add[0] !== 7'd0) begin errors++; $display("FAIL conv_slot_zero got %0d exp 0", add[0]); end
  endtask

  task automatic test_start_handling();
    do_start();
    checks++; if ({il[0], dn[0], cv[0], tmo[0]} !== 4'b1000 || it[0] !== 16'd0) begin errors++; $display("FAIL start_in_done got %b iter %0d exp 1000 iter 0", {il[0], dn[0], cv[0], tmo[0]}, it[0]); end
    run_to_slot(2, 7'd10, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL busy_reach got %b exp 1", ok); end
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    checks++; if ({il[0], en[0], bsy[0]} !== 3'b001 || it[0] !== 16'd2) begin errors++; $display("FAIL start_busy got %b iter %0d exp 001 iter 2", {il[0], en[0], bsy[0]}, it[0]); end
    wait_done(0, 400, ok);
    checks++; if (ok !== 1'b1 || it[0] !== 16'd9 || cv[0] !== 1'b1) begin errors++; $display("FAIL busy_finish got ok %b iter %0d conv %b exp 1 9 1", ok, it[0], cv[0]); end
  endtask

  task automatic test_abort_load();
    do_start();
    abort = 1'b1;
    checks++; if (il[0] !== 1'b1) begin errors++; $display("FAIL abort_load_pulse got %b exp 1", il[0]); end
    @(negedge clk) abort = 1'b0;
    checks++; if ({dn[0], en[0], bsy[0], cv[0], tmo[0], il[0]} !== 6'b110000 || it[0] !== 16'd0) begin errors++; $display("FAIL abort_load got %b iter %0d exp 110000 iter 0", {dn[0], en[0], bsy[0], cv[0], tmo[0], il[0]}, it[0]); end
    @(negedge clk);
    checks++; if (add[0] !== 7'd0) begin errors++; $display("FAIL abort_load_slot got %0d exp 0", add[0]); end
  endtask

  task automatic test_timeout();
    pulse_reset();
    for (int i = 0; i < 32; i++) seq[i] = (i % 2 == 1) ? 16'sd100 : 16'sd0;
    seq_el = 1; seq_k = 0; apply_x(0);
    do_start();
    wait_done(1, 400, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL to_wait got %b exp 1", ok); end
    checks++; if ({tmo[1], cv[1]} !== 2'b10 || it[1] !== 16'd5) begin errors++; $display("FAIL to_flags got %b iter %0d exp 10 iter 5", {tmo[1], cv[1]}, it[1]); end
    checks++; if ({bsy[0], dn[0]} !== 2'b10) begin errors++; $display("FAIL to_nonconv got %b exp 10", {bsy[0], dn[0]}); end
  endtask

  task automatic test_abort_run();
    pulse_reset();
    fill_seq(16'sd0); seq_el = 0; seq_k = 0; apply_x(0);
    do_start();
    run_to_slot(3, 7'd7, ok);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL abort_reach got %b exp 1", ok); end
    while (add[0] != 7'd20 && ok) @(negedge clk);
    checks++; if ({en[0], dn[0]} !== 2'b00) begin errors++; $display("FAIL abort_slot20 got %b exp 00", {en[0], dn[0]}); end
    @(negedge clk);
    checks++; if ({dn[0], en[0], cv[0], tmo[0]} !== 4'b1100 || it[0] !== 16'd3) begin errors++; $display("FAIL abort_run got %b iter %0d exp 1100 iter 3", {dn[0], en[0], cv[0], tmo[0]}, it[0]); end
    checks++; if ({dn[1], tmo[1]} !== 2'b10) begin errors++; $display("FAIL abort_max5 got %b exp 10", {dn[1], tmo[1]}); end
  endtask

  task automatic test_reset_mid();
    do_start();
    run_to_slot(2, 7'd13, ok);
    reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    checks++; if ({en[0], il[0], bsy[0], dn[0], cv[0], tmo[0]} !== 6'b100000 || it[0] !== 16'd0) begin errors++; $display("FAIL reset_mid got %b iter %0d exp 100000 iter 0", {en[0], il[0], bsy[0], dn[0], cv[0], tmo[0]}, it[0]); end
    @(negedge clk);
    checks++; if (add[0] !== 7'd0) begin errors++; $display("FAIL reset_mid_slot got %0d exp 0", add[0]); end
    seq_k = 0; apply_x(0);
    do_start();
    wait_done(0, 400, ok);
    checks++; if (ok !== 1'b1 || it[0] !== 16'd9 || cv[0] !== 1'b1) begin errors++; $display("FAIL reset_restart got ok %b iter %0d conv %b exp 1 9 1", ok, it[0], cv[0]); end
  endtask

  task automatic test_tolerance();
    pulse_reset();
    seq[0] = 16'sd0;
    for (int i = 1; i < 8; i++) seq[i] = -16'(4 * i);
    seq[8] = -16'sd23;
    for (int i = 9; i < 32; i++) seq[i] = (i < 17) ? 16'(-23 + 4 * (i - 8)) : 16'sd9;
    seq_el = 3; seq_k = 0; apply_x(0);
    do_start();
    wait_done(0, 500, ok);
    checks++; if (ok !== 1'b1 || it[0] !== 16'd17 || cv[0] !== 1'b1) begin errors++; $display("FAIL tol_edge got ok %b iter %0d conv %b exp 1 17 1", ok, it[0], cv[0]); end
  endtask

  task automatic test_swing();
    pulse_reset();
    for (int i = 0; i < 32; i++) seq[i] = (i < 8) ? -16'sd32768 : 16'sd32767;
    seq_el = 0; seq_k = 0; apply_x(0);
    do_start();
    wait_done(0, 500, ok);
    checks++; if (ok !== 1'b1 || it[0] !== 16'd17 || cv[0] !== 1'b1) begin errors++; $display("FAIL full_swing got ok %b iter %0d conv %b exp 1 17 1", ok, it[0], cv[0]); end
  endtask

  initial begin
    for (int d = 0; d < ND; d++) add[d] = 7'd0;
    fill_seq(16'sd0);
    test_reset();
    test_converge();
    test_start_handling();
    test_abort_load();
    test_timeout();
    test_abort_run();
    test_reset_mid();
    test_tolerance();
    test_swing();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
